// File: rtl/inv_ps4_num_pkg.sv
// -----------------------------------------------------------------------------
// inv_ps4_num_pkg
//   Shared sizing for the 4-requester inverted-priority selector.
//   Cache users import this to size fetch_idx and related fields.
//
//   PS4_REQ_W : number of requesters (request vector width)
//   PS4_IDX_W : width of the binary index returned by the selector
//
//   ps4_onehot() expands a binary index into a one-hot vector. It is used
//   by the optional grant output (INV_PS4_NUM_GNT_EN).
// -----------------------------------------------------------------------------
package inv_ps4_num_pkg;

  localparam int PS4_REQ_W = 4;
  localparam int PS4_IDX_W = 2;

  typedef logic [PS4_REQ_W-1:0] ps4_req_t;
  typedef logic [PS4_IDX_W-1:0] ps4_idx_t;

  // Binary index -> one-hot, gated by a valid flag so "no request" maps to 0.
  function automatic ps4_req_t ps4_onehot(input ps4_idx_t idx, input logic valid);
    ps4_req_t oh;
    oh = '0;
    if (valid) begin
      oh[idx] = 1'b1;
    end
    return oh;
  endfunction

endpackage : inv_ps4_num_pkg

// File: rtl/inv_ps2.sv
// -----------------------------------------------------------------------------
// inv_ps2
//   2-requester inverted-priority cell; bit 0 wins.
//
//   req [1:0] in  : request pair
//   idx       out : 1 only when req[1] is set and req[0] is clear
//   en        out : OR of the pair
//
//   idx is written as an AND so that a 1 on req[0] forces idx to 0 even when
//   req[1] is unknown, and so that an empty pair reports idx = 0. The root
//   instance relies on the latter: with no request at all, the high pair is
//   not selected and the overall index collapses to 0.
// -----------------------------------------------------------------------------
module inv_ps2 (
  input  logic [1:0] req,
  output logic       idx,
  output logic       en
);

  assign idx = ~req[0] & req[1];
  assign en  = req[0] | req[1];

endmodule : inv_ps2

// File: rtl/inv_ps4_num.sv
// -----------------------------------------------------------------------------
// inv_ps4_num
//   4-requester inverted-priority selector: reports the index of the
//   lowest-numbered asserted request (req[0] highest priority). Used by the
//   instruction-cache prefetcher so the demand slot (0) beats prefetch slots.
//
//   clock      in  : system clock (registered copies update on rising edge)
//   reset      in  : asynchronous active-low reset, clears num_r / en_r only
//   req  [3:0] in  : request vector, bit i = requester i wants service
//   num  [1:0] out : combinational lowest-set-bit index (0 when req == 0)
//   en         out : combinational OR of req
//   num_r[1:0] out : num registered
//   en_r       out : en registered
//   gnt  [3:0] out : one-hot grant, present only when INV_PS4_NUM_GNT_EN
//                    is defined
//
//   Build option: define INV_PS4_NUM_GNT_EN to add the gnt port.
//
//   The selector is stateless with respect to requests: it never consumes or
//   clears them. Round-robin or consumption is the caller's job (mask req).
// -----------------------------------------------------------------------------
module inv_ps4_num
  import inv_ps4_num_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [PS4_REQ_W-1:0] req,
  output logic [PS4_IDX_W-1:0] num,
  output logic                 en,
`ifdef INV_PS4_NUM_GNT_EN
  output logic [PS4_REQ_W-1:0] gnt,
`endif
  output logic [PS4_IDX_W-1:0] num_r,
  output logic                 en_r
);

  // Level 1: one cell per request pair. Index 0 = pair (0,1), 1 = pair (2,3).
  logic [1:0] pair_idx;
  logic [1:0] pair_en;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_leaf
      inv_ps2 u_leaf (
        .req (req[2*gi+1:2*gi]),
        .idx (pair_idx[gi]),
        .en  (pair_en[gi])
      );
    end
  endgenerate

  // Level 2: the same cell arbitrates between the pair enables. Its idx is
  // the "high pair selected" bit, i.e. the MSB of the final index.
  logic hi_sel;
  logic root_en;

  inv_ps2 u_root (
    .req (pair_en),
    .idx (hi_sel),
    .en  (root_en)
  );

  // When hi_sel is 0 the low pair's local index is used; with req == 0 both
  // local indices are 0, giving num = 0.
  assign num = {hi_sel, (hi_sel ? pair_idx[1] : pair_idx[0])};
  assign en  = root_en;

`ifdef INV_PS4_NUM_GNT_EN
  assign gnt = ps4_onehot(num, en);

  // The grant can never name more than one requester.
  always_comb begin
    assert ($onehot0(gnt));
  end
`endif

  // Pipelined copy for downstream consumers. Reset deassertion is already
  // synchronised upstream, so a plain async clear is sufficient here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      num_r <= '0;
      en_r  <= 1'b0;
    end else begin
      num_r <= num;
      en_r  <= en;
    end
  end

endmodule : inv_ps4_num

// File: tb/tb_inv_ps4_num.sv
// -----------------------------------------------------------------------------
// tb_inv_ps4_num
//   Directed bench for inv_ps4_num. A behavioural model (lowest-set-bit search
//   plus an ideal register) is compared against the DUT on every falling
//   clock edge; directed steps add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_inv_ps4_num;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [1:0] num;
  logic       en;
  logic [1:0] num_r;
  logic       en_r;
`ifdef INV_PS4_NUM_GNT_EN
  logic [3:0] gnt;
`endif

  int checks = 0;
  int errors = 0;

  inv_ps4_num dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .num   (num),
    .en    (en),
`ifdef INV_PS4_NUM_GNT_EN
    .gnt   (gnt),
`endif
    .num_r (num_r),
    .en_r  (en_r)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- behavioural model ----------------
  // Lowest requester that is definitely asserted; tolerant of X on others.
  function automatic int model_idx(input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      if (r[i] === 1'b1) return i;
    end
    return 0;
  endfunction

  function automatic logic model_en(input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      if (r[i] === 1'b1) return 1'b1;
    end
    return 1'b0;
  endfunction

  int   m_num_r;
  logic m_en_r;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_num_r = 0;
      m_en_r  = 1'b0;
    end else begin
      m_num_r = model_idx(req);
      m_en_r  = model_en(req);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (req=%b t=%0t)", name, act, exp, req, $time);
    end
  endtask

  // Compare process: outputs are meaningful on every falling edge.
  bit run_cmp = 1'b0;
  always @(negedge clock) begin
    if (run_cmp) begin
      check("cmp_num",   int'(num),   model_idx(req));
      check("cmp_en",    int'(en),    int'(model_en(req)));
      check("cmp_num_r", int'(num_r), m_num_r);
      check("cmp_en_r",  int'(en_r),  int'(m_en_r));
`ifdef INV_PS4_NUM_GNT_EN
      check("cmp_gnt", int'(gnt),
            model_en(req) ? (1 << model_idx(req)) : 0);
`endif
    end
  end

  // Hand-computed lowest-set-bit index for req = 0..15.
  int lsb_tab [16] = '{0, 0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0};

  // Drive req a little after a rising edge, then check the literal result.
  task automatic apply(input logic [3:0] v, input int exp_num, input int exp_en);
    @(posedge clock);
    #2;
    req = v;
    #1;
    check("num", int'(num), exp_num);
    check("en",  int'(en),  exp_en);
    $display("req=%b num=%0d en=%0d (expect %0d/%0d)", v, num, en, exp_num, exp_en);
  endtask

  initial begin
    logic [3:0] r;
    reset = 1'b0;
    req   = 4'b0000;
    #1;
    check("reset_num_r", int'(num_r), 0);
    check("reset_en_r",  int'(en_r),  0);
    #11;
    reset   = 1'b1;
    run_cmp = 1'b1;

    // Exhaustive sweep with literal table.
    for (int i = 0; i < 16; i++) begin
      r = 4'(i);
      apply(r, lsb_tab[i], (i != 0) ? 1 : 0);
`ifdef INV_PS4_NUM_GNT_EN
      check("gnt_sweep", int'(gnt), int'(r & (~r + 4'd1)));
`endif
    end

    // Directed patterns.
    apply(4'b1010, 1, 1);
    apply(4'b1000, 3, 1);
    apply(4'b0100, 2, 1);
    apply(4'b1101, 0, 1);
    apply(4'b0000, 0, 0);
    apply(4'b0001, 0, 1);

    // Registered path: capture, then mid-cycle change must not show early.
    apply(4'b1100, 2, 1);
    @(posedge clock);
    #1;
    check("num_r_cap", int'(num_r), 2);
    check("en_r_cap",  int'(en_r),  1);
    $display("reg capture num_r=%0d en_r=%0d", num_r, en_r);
    #2;
    req = 4'b0000;
    #1;
    check("num_r_hold", int'(num_r), 2);
    check("en_r_hold",  int'(en_r),  1);
    @(posedge clock);
    #1;
    check("num_r_clr", int'(num_r), 0);
    check("en_r_clr",  int'(en_r),  0);
    $display("reg after idle num_r=%0d en_r=%0d", num_r, en_r);

    // Asynchronous reset between edges.
    apply(4'b1000, 3, 1);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("rst_num_r", int'(num_r), 0);
    check("rst_en_r",  int'(en_r),  0);
    check("rst_num",   int'(num),   3);
    check("rst_en",    int'(en),    1);
    $display("async reset num_r=%0d en_r=%0d num=%0d", num_r, en_r, num);
    #1;
    reset = 1'b1;
    #1;
    check("rel_num_r_wait", int'(num_r), 0);
    @(posedge clock);
    #1;
    check("rel_num_r", int'(num_r), 3);
    check("rel_en_r",  int'(en_r),  1);
    $display("after release num_r=%0d en_r=%0d", num_r, en_r);

    // Unknown lower-priority bits must not disturb the index.
    @(posedge clock);
    #2;
    req = 4'bxxx1;
    #1;
    check("x_num", int'(num), 0);
    check("x_en",  int'(en),  1);
    checks++;
    if ((^num) === 1'bx) begin
      errors++;
      $display("FAIL x_num_known: got %b expected 00", num);
    end
    $display("req=xxx1 num=%b en=%b", num, en);
    @(posedge clock);
    #2;
    req = 4'b0000;
    repeat (2) @(posedge clock);
    #1;
    run_cmp = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_inv_ps4_num
